// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment pattern constants and anode polarity helper.
package seg_pkg;

    localparam int SEGB_A = 0;
    localparam int SEGB_B = 1;
    localparam int SEGB_C = 2;
    localparam int SEGB_D = 3;
    localparam int SEGB_E = 4;
    localparam int SEGB_F = 5;
    localparam int SEGB_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic [6:0] SEG_LUT [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

    // Maps a logical "digit on" to the pin level for the board's anode polarity.
    function automatic logic an_level(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: nibble to active-high segment pattern (bit0=a .. bit6=g).
module seven_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       hex_en_i,
    output logic [6:0] seg_o
);

    assign seg_o = (!hex_en_i && nib_i > 4'd9) ? SEG_BLANK : SEG_LUT[nib_i];

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed N-digit seven-segment scanner with double-buffered
// value, leading-zero blanking, per-digit decimal points and inter-digit guard.
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 1000,
    parameter int GUARD         = 2,
    parameter int HEX_EN        = 1,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    blank_lz_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    pending_o,
    output logic                    frame_o
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_P  = PW'(GUARD);
    localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);
    localparam logic          AL       = AN_ACTIVE_LOW != 0;
    localparam logic          AN_OFF   = an_level(1'b0, AL);

    logic [PW-1:0]         ps_q, ps_d;
    logic [DW-1:0]         dig_q, dig_d;
    logic [VW-1:0]         sh_val_q, sh_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic                  pend_q, pend_d, frame_q, frame_d, dp_q, dp_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  boundary, xfer, show, blanked, lz_sel, dp_bit, zero;
    logic [3:0]            nib;
    logic [6:0]            pat;
    logic [NUM_DIGITS-1:0] lz_vec;

    assign boundary = enable_i && ps_q == PS_LAST && dig_q == DIG_LAST;
    // While disabled there are no boundaries, so the shadow drains immediately.
    assign xfer     = boundary || !enable_i;

    always_comb begin
        ps_d      = (!enable_i || ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
        dig_d     = !enable_i ? '0 : (ps_q != PS_LAST) ? dig_q : (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
        sh_val_d  = load_i ? value_i : sh_val_q;
        sh_dp_d   = load_i ? dp_i : sh_dp_q;
        act_val_d = (load_i && boundary) ? value_i : (xfer && pend_q) ? sh_val_q : act_val_q;
        act_dp_d  = (load_i && boundary) ? dp_i : (xfer && pend_q) ? sh_dp_q : act_dp_q;
        pend_d    = load_i ? !boundary : pend_q && !xfer;
        frame_d   = boundary;
    end

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        zero   = 1'b1;
        lz_vec = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero      = zero && (act_val_q[4*k +: 4] == 4'h0);
            lz_vec[k] = zero && (k != 0);
        end
    end

    always_comb begin
        nib    = 4'h0;
        dp_bit = 1'b0;
        lz_sel = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (DW'(k) == dig_q) begin
                nib    = act_val_q[4*k +: 4];
                dp_bit = act_dp_q[k];
                lz_sel = lz_vec[k];
            end
        end
    end

    seven_seg_decode u_decode (
        .nib_i    (nib),
        .hex_en_i (HEX_EN != 0),
        .seg_o    (pat)
    );

    assign show    = enable_i && ps_q >= GUARD_P;
    assign blanked = blank_lz_i && lz_sel;

    always_comb begin
        seg_d = (show && !blanked) ? pat : SEG_BLANK;
        dp_d  = show && dp_bit;
        an_d  = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            an_d[k] = an_level(show && (!blanked || dp_bit) && DW'(k) == dig_q, AL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q      <= '0;
            dig_q     <= '0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            pend_q    <= 1'b0;
            frame_q   <= 1'b0;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b0;
            an_q      <= {NUM_DIGITS{AN_OFF}};
        end else begin
            ps_q      <= ps_d;
            dig_q     <= dig_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            pend_q    <= pend_d;
            frame_q   <= frame_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign seg_o     = seg_q;
    assign dp_o      = dp_q;
    assign an_o      = an_q;
    assign pending_o = pend_q;
    assign frame_o   = frame_q;

endmodule
